// File: rtl/operand_fetch_fwd.sv
// Operand fetch: 128x128 register file, three-operand read with newest-first forwarding bypass.
// Latency: 1 cycle from address presentation to registered op_ra/op_rb/op_rc/op_valid.
// Backpressure: stall holds the RF/EX register; register-file writes proceed regardless of stall.
module operand_fetch_fwd #(
    parameter int NREGS = 128,
    parameter int DW    = 128,
    parameter int NSTG  = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_en,
    input  logic          stall,
    input  logic [0:6]    addr_ra,
    input  logic [0:6]    addr_rb,
    input  logic [0:6]    addr_rc,
    input  logic [0:134]  fw_chk_even_1,
    input  logic [0:134]  fw_chk_even_2,
    input  logic [0:134]  fw_chk_even_3,
    input  logic [0:134]  fw_chk_even_4,
    input  logic [0:134]  fw_chk_even_5,
    input  logic [0:134]  fwd_even_data,
    input  logic [0:134]  fw_chk_odd_1,
    input  logic [0:134]  fw_chk_odd_2,
    input  logic [0:134]  fw_chk_odd_3,
    input  logic [0:134]  fw_chk_odd_4,
    input  logic [0:134]  fw_chk_odd_5,
    input  logic [0:134]  fwd_odd_data,
    output logic [0:127]  op_ra,
    output logic [0:127]  op_rb,
    output logic [0:127]  op_rc,
    output logic          op_valid
);
    localparam int AW    = 7;
    localparam int BW    = AW + DW;
    localparam int NBND  = 2 * NSTG + 2;

    logic [0:DW-1] rf [NREGS];
    logic [0:BW-1] bnd [NBND];
    logic [0:AW-1] src_addr [3];
    logic [0:DW-1] res [3];

    // Bundles in strict priority order: index 0 is the newest (even_1), last is odd writeback.
    always_comb begin
        bnd[0]  = fw_chk_even_1;
        bnd[1]  = fw_chk_odd_1;
        bnd[2]  = fw_chk_even_2;
        bnd[3]  = fw_chk_odd_2;
        bnd[4]  = fw_chk_even_3;
        bnd[5]  = fw_chk_odd_3;
        bnd[6]  = fw_chk_even_4;
        bnd[7]  = fw_chk_odd_4;
        bnd[8]  = fw_chk_even_5;
        bnd[9]  = fw_chk_odd_5;
        bnd[10] = fwd_even_data;
        bnd[11] = fwd_odd_data;
        src_addr[0] = addr_ra;
        src_addr[1] = addr_rb;
        src_addr[2] = addr_rc;
    end

    // Walk from oldest to newest so the highest-priority match is applied last.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            res[k] = rf[src_addr[k]];
            for (int i = NBND - 1; i >= 0; i--) begin
                if (src_addr[k] != '0 && bnd[i][0:AW-1] == src_addr[k]) begin
                    res[k] = bnd[i][AW:BW-1];
                end
            end
        end
    end

    // Even write is issued second so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (fwd_odd_data[0:AW-1] != '0) begin
                rf[fwd_odd_data[0:AW-1]] <= fwd_odd_data[AW:BW-1];
            end
            if (fwd_even_data[0:AW-1] != '0) begin
                rf[fwd_even_data[0:AW-1]] <= fwd_even_data[AW:BW-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_ra    <= '0;
            op_rb    <= '0;
            op_rc    <= '0;
            op_valid <= 1'b0;
        end else if (!stall) begin
            op_ra    <= res[0];
            op_rb    <= res[1];
            op_rc    <= res[2];
            op_valid <= rd_en;
        end
    end
endmodule

// File: tb/tb_operand_fetch_fwd.sv
// Bench for operand_fetch_fwd: directed scenarios plus randomized traffic against a behavioural model.
module tb_operand_fetch_fwd;
    logic         clk = 1'b0;
    logic         reset;
    logic         rd_en, stall;
    logic [0:6]   addr_ra, addr_rb, addr_rc;
    logic [0:134] fe [1:5];
    logic [0:134] fo [1:5];
    logic [0:134] fwe, fwo;
    logic [0:127] op_ra, op_rb, op_rc;
    logic         op_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] mrf [128];
    logic [127:0] exp_ra, exp_rb, exp_rc;
    logic         exp_valid;

    always #5 clk = ~clk;

    operand_fetch_fwd dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .stall(stall),
        .addr_ra(addr_ra), .addr_rb(addr_rb), .addr_rc(addr_rc),
        .fw_chk_even_1(fe[1]), .fw_chk_even_2(fe[2]), .fw_chk_even_3(fe[3]),
        .fw_chk_even_4(fe[4]), .fw_chk_even_5(fe[5]), .fwd_even_data(fwe),
        .fw_chk_odd_1(fo[1]), .fw_chk_odd_2(fo[2]), .fw_chk_odd_3(fo[3]),
        .fw_chk_odd_4(fo[4]), .fw_chk_odd_5(fo[5]), .fwd_odd_data(fwo),
        .op_ra(op_ra), .op_rb(op_rb), .op_rc(op_rc), .op_valid(op_valid)
    );

    function automatic logic [0:134] mk(input logic [6:0] a, input logic [127:0] d);
        return {a, d};
    endfunction

    // Newest-first search over the forwarding sources, then the model register file.
    function automatic logic [127:0] ref_resolve(input logic [6:0] a);
        logic [0:134] order [$];
        for (int s = 1; s <= 5; s++) begin
            order.push_back(fe[s]);
            order.push_back(fo[s]);
        end
        order.push_back(fwe);
        order.push_back(fwo);
        if (a != 7'd0) begin
            foreach (order[i]) begin
                if (order[i][0:6] == a) return order[i][7:134];
            end
        end
        return mrf[a];
    endfunction

    task automatic clr_in();
        rd_en = 1'b0; stall = 1'b0;
        addr_ra = '0; addr_rb = '0; addr_rc = '0;
        for (int s = 1; s <= 5; s++) begin
            fe[s] = '0;
            fo[s] = '0;
        end
        fwe = '0; fwo = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) mrf[i] = '0;
        exp_ra = '0; exp_rb = '0; exp_rc = '0; exp_valid = 1'b0;
    endtask

    // One clock: resolve with pre-edge state, then apply the edge to the model; ends on negedge.
    task automatic step();
        logic [127:0] va, vb, vc;
        va = ref_resolve(addr_ra);
        vb = ref_resolve(addr_rb);
        vc = ref_resolve(addr_rc);
        @(posedge clk);
        if (!stall) begin
            exp_ra = va; exp_rb = vb; exp_rc = vc; exp_valid = rd_en;
        end
        if (fwo[0:6] != 7'd0) mrf[fwo[0:6]] = fwo[7:134];
        if (fwe[0:6] != 7'd0) mrf[fwe[0:6]] = fwe[7:134];
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clr_in();
        model_clear();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({op_ra, op_rb, op_rc, op_valid} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got valid=%b ra=%h exp all zero", op_valid, op_ra);
        end
        reset = 1'b0;
        rd_en = 1'b1; addr_ra = 7'd5; addr_rb = 7'd5; addr_rc = 7'd5;
        step();
        n_vec++;
        if (op_ra !== 128'd0 || op_rb !== 128'd0 || op_rc !== 128'd0) begin
            n_err++; $display("FAIL reset_read_r5: got %h %h %h exp 0", op_ra, op_rb, op_rc);
        end
        n_vec++;
        if (op_valid !== 1'b1) begin
            n_err++; $display("FAIL reset_read_valid: got %b exp 1", op_valid);
        end
    endtask

    task automatic test_write_read();
        logic [127:0] a5 = {16{8'hA5}};
        clr_in();
        fwe = mk(7'd5, a5); rd_en = 1'b1; addr_rb = 7'd5;
        step();
        n_vec++;
        if (op_rb !== a5) begin
            n_err++; $display("FAIL same_cycle_bypass: got %h exp %h", op_rb, a5);
        end
        clr_in();
        rd_en = 1'b1; addr_ra = 7'd5;
        step();
        n_vec++;
        if (op_ra !== a5) begin
            n_err++; $display("FAIL rf_readback: got %h exp %h", op_ra, a5);
        end
    endtask

    task automatic test_reset_midrun();
        clr_in();
        stall = 1'b1; rd_en = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({op_ra, op_rb, op_rc, op_valid} !== '0) begin
            n_err++; $display("FAIL midrun_reset_async: got valid=%b ra=%h exp all zero", op_valid, op_ra);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; addr_ra = 7'd5;
        step();
        n_vec++;
        if (op_ra !== 128'd0 || op_valid !== 1'b1) begin
            n_err++; $display("FAIL midrun_reset_r5: got %h/%b exp 0/1", op_ra, op_valid);
        end
    endtask

    task automatic test_depth_priority();
        logic [127:0] w = {4{32'h57575757}};
        logic [127:0] x = {4{32'h0000_00AA}};
        logic [127:0] y = {4{32'h1111_2222}};
        logic [127:0] z = {4{32'hDEAD_BEEF}};
        clr_in();
        fwe = mk(7'd9, w);
        step();
        clr_in();
        rd_en = 1'b1; addr_rb = 7'd9;
        fe[3] = mk(7'd9, x); fo[1] = mk(7'd9, y); fwo = mk(7'd9, z);
        step();
        n_vec++;
        if (op_rb !== y) begin n_err++; $display("FAIL depth_odd1: got %h exp %h", op_rb, y); end
        fo[1] = '0;
        step();
        n_vec++;
        if (op_rb !== x) begin n_err++; $display("FAIL depth_even3: got %h exp %h", op_rb, x); end
        fe[3] = '0;
        step();
        n_vec++;
        if (op_rb !== z) begin n_err++; $display("FAIL depth_wb_odd: got %h exp %h", op_rb, z); end
        fwo = '0; fwe = mk(7'd9, w);
        step();
        fwe = '0;
        step();
        n_vec++;
        if (op_rb !== w) begin n_err++; $display("FAIL depth_rf: got %h exp %h", op_rb, w); end
    endtask

    task automatic test_tie();
        logic [127:0] e = {8{16'hEEEE}};
        logic [127:0] o = {8{16'h0D0D}};
        clr_in();
        rd_en = 1'b1; addr_rc = 7'd12;
        fe[2] = mk(7'd12, e); fo[2] = mk(7'd12, o);
        step();
        n_vec++;
        if (op_rc !== e) begin n_err++; $display("FAIL tie_stage2: got %h exp %h", op_rc, e); end
        clr_in();
        fwe = mk(7'd12, e); fwo = mk(7'd12, o);
        step();
        clr_in();
        rd_en = 1'b1; addr_rc = 7'd12;
        step();
        n_vec++;
        if (op_rc !== e) begin n_err++; $display("FAIL tie_writeback_rf: got %h exp %h", op_rc, e); end
    endtask

    task automatic test_stall();
        logic [127:0] q = {2{64'h0123_4567_89AB_CDEF}};
        logic [127:0] r = {2{64'hFEDC_BA98_7654_3210}};
        clr_in();
        rd_en = 1'b1; addr_ra = 7'd3; fe[1] = mk(7'd3, q);
        step();
        n_vec++;
        if (op_ra !== q) begin n_err++; $display("FAIL stall_capture: got %h exp %h", op_ra, q); end
        stall = 1'b1; rd_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            addr_ra = 7'(c + 20);
            fe[1] = mk(7'(c + 20), r);
            fwe = mk(7'(c + 40), r);
            step();
            n_vec++;
            if (op_ra !== q || op_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_hold%0d: got %h/%b exp %h/1", c, op_ra, op_valid, q);
            end
        end
        stall = 1'b0; rd_en = 1'b1; addr_ra = 7'd40; fe[1] = '0; fwe = '0;
        step();
        n_vec++;
        if (op_ra !== r) begin n_err++; $display("FAIL stall_release: got %h exp %h", op_ra, r); end
    endtask

    task automatic test_bubble();
        clr_in();
        rd_en = 1'b1; addr_ra = 7'd0;
        fe[1] = mk(7'd0, '1); fwe = mk(7'd0, '1);
        step();
        n_vec++;
        if (op_ra !== 128'd0) begin n_err++; $display("FAIL bubble_match: got %h exp 0", op_ra); end
        clr_in();
        rd_en = 1'b1;
        step();
        n_vec++;
        if (op_ra !== 128'd0) begin n_err++; $display("FAIL bubble_r0_write: got %h exp 0", op_ra); end
        rd_en = 1'b0;
        step();
        n_vec++;
        if (op_valid !== 1'b0) begin n_err++; $display("FAIL rd_en_low: got %b exp 0", op_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rd_en = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            addr_ra = 7'($urandom_range(0, 7));
            addr_rb = 7'($urandom_range(0, 7));
            addr_rc = 7'($urandom_range(0, 7));
            for (int s = 1; s <= 5; s++) begin
                fe[s] = mk(7'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
                fo[s] = mk(7'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
            end
            fwe = mk(7'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
            fwo = mk(7'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
            step();
            n_vec++;
            if (op_ra !== exp_ra || op_rb !== exp_rb || op_rc !== exp_rc || op_valid !== exp_valid) begin
                n_err++;
                $display("FAIL random%0d: got ra=%h rb=%h rc=%h v=%b exp ra=%h rb=%h rc=%h v=%b",
                         c, op_ra, op_rb, op_rc, op_valid, exp_ra, exp_rb, exp_rc, exp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset_midrun();
        test_depth_priority();
        test_tie();
        test_stall();
        test_bubble();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
